// File: rtl/bit_deserializer_if.sv
// Handshake bundle for bit_deserializer: serial bit input side, assembled-word output side, word counter.
// The master drives bits and consumes words; the slave is the deserializer.
interface bit_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       word_cnt;

  modport master (
    output in_bit, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, word_cnt
  );

  modport slave (
    input  in_bit, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, word_cnt
  );
endinterface

// File: rtl/bit_deserializer.sv
// Serial-to-parallel: WIDTH bits (LSB first) -> one word; out_valid one cycle after the last bit, no bubble.
// Backpressure: only the last bit of the next word stalls (in_ready=0) while a held word is unconsumed.
module bit_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  bit_deserializer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] od_q, od_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       word_cnt_q, word_cnt_d;

  logic in_rdy;
  logic acc;
  logic last;
  logic out_hs;

  assign last   = (cnt_q == LAST);
  // Completing a word is the only move that needs the output register free.
  assign in_rdy = ~bus.flush & ~(last & out_valid_q & ~bus.out_ready);
  assign acc    = bus.in_valid & in_rdy;
  assign out_hs = out_valid_q & bus.out_ready;

  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    od_d        = od_q;
    out_valid_d = out_valid_q;
    word_cnt_d  = word_cnt_q + 8'(out_hs);

    if (out_hs) begin
      out_valid_d = 1'b0;
    end

    if (bus.flush) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (acc) begin
      if (last) begin
        od_d        = {bus.in_bit, sr_q[WIDTH-2:0]};
        out_valid_d = 1'b1;
        sr_d        = '0;
        cnt_d       = '0;
      end else begin
        sr_d[cnt_q] = bus.in_bit;
        cnt_d       = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      od_q        <= '0;
      out_valid_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      od_q        <= od_d;
      out_valid_q <= out_valid_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_data  = od_q;
  assign bus.out_valid = out_valid_q;
  assign bus.word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench for bit_deserializer (WIDTH=8): basic, back-to-back, backpressure, flush, reset, wrap.
module tb_bit_deserializer;

  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;
  logic [7:0] exp_wc;

  bit_deserializer_if #(.WIDTH(8)) bus ();

  bit_deserializer #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_bit = 1'b1;
    bus.in_valid = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.word_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h cnt=%h, want 0 00 00", bus.out_valid, bus.out_data, bus.word_cnt);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    tick();
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.word_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_held: got valid=%b data=%h cnt=%h, want 0 00 00", bus.out_valid, bus.out_data, bus.word_cnt);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_wc = 8'h00;
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'h4D;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit = w[i];
      tick();
      if (i < 7) begin
        vectors++;
        if (bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_early_valid: bit %0d got %b want 0", i, bus.out_valid);
        end
      end
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h4D) begin
      errors++;
      $display("FAIL basic_word: got valid=%b data=%h want 1 4d", bus.out_valid, bus.out_data);
    end
    tick();
    exp_wc = exp_wc + 8'd1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.word_cnt !== exp_wc) begin
      errors++;
      $display("FAIL basic_consume: got valid=%b cnt=%0d want 0 %0d", bus.out_valid, bus.word_cnt, exp_wc);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] stream;
    logic [7:0]  w;
    stream = 24'h00FF4D;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit = stream[i];
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready: bit %0d got %b want 1", i, bus.in_ready);
      end
      tick();
      w = stream[(i/8)*8 +: 8];
      vectors++;
      if ((i % 8) == 7) begin
        if (bus.out_valid !== 1'b1 || bus.out_data !== w) begin
          errors++;
          $display("FAIL b2b_word: bit %0d got valid=%b data=%h want 1 %h", i, bus.out_valid, bus.out_data, w);
        end
      end else if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_gap: bit %0d got valid=%b want 0", i, bus.out_valid);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    exp_wc = exp_wc + 8'd3;
    vectors++;
    if (bus.word_cnt !== exp_wc || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: got cnt=%0d valid=%b want %0d 0", bus.word_cnt, bus.out_valid, exp_wc);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] w1;
    logic [7:0] w2;
    w1 = 8'h4D;
    w2 = 8'hA5;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit = w1[i];
      tick();
    end
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h4D) begin
      errors++;
      $display("FAIL bp_first: got valid=%b data=%h want 1 4d", bus.out_valid, bus.out_data);
    end
    for (int i = 0; i < 7; i++) begin
      bus.in_bit = w2[i];
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_collect_ready: bit %0d got %b want 1", i, bus.in_ready);
      end
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h4D) begin
        errors++;
        $display("FAIL bp_hold: bit %0d got valid=%b data=%h want 1 4d", i, bus.out_valid, bus.out_data);
      end
    end
    bus.in_bit = w2[7];
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall_ready: cycle %0d got %b want 0", k, bus.in_ready);
      end
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h4D || bus.word_cnt !== exp_wc) begin
        errors++;
        $display("FAIL bp_stall_hold: got valid=%b data=%h cnt=%0d want 1 4d %0d", bus.out_valid, bus.out_data, bus.word_cnt, exp_wc);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
    end
    tick();
    exp_wc = exp_wc + 8'd1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.word_cnt !== exp_wc) begin
      errors++;
      $display("FAIL bp_swap: got valid=%b data=%h cnt=%0d want 1 a5 %0d", bus.out_valid, bus.out_data, bus.word_cnt, exp_wc);
    end
    bus.in_valid = 1'b0;
    tick();
    exp_wc = exp_wc + 8'd1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.word_cnt !== exp_wc) begin
      errors++;
      $display("FAIL bp_drain: got valid=%b cnt=%0d want 0 %0d", bus.out_valid, bus.word_cnt, exp_wc);
    end
  endtask

  task automatic test_flush();
    logic [7:0] w;
    w = 8'h3C;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit = 1'b1;
      tick();
    end
    bus.flush = 1'b1;
    bus.in_bit = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready: got %b want 0", bus.in_ready);
    end
    tick();
    bus.flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit = w[i];
      tick();
      if (i < 7) begin
        vectors++;
        if (bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL flush_stale: bit %0d got valid=%b want 0", i, bus.out_valid);
        end
      end
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin
      errors++;
      $display("FAIL flush_word: got valid=%b data=%h want 1 3c", bus.out_valid, bus.out_data);
    end
    bus.flush = 1'b1;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || bus.word_cnt !== exp_wc) begin
      errors++;
      $display("FAIL flush_keeps_output: got valid=%b data=%h cnt=%0d want 1 3c %0d", bus.out_valid, bus.out_data, bus.word_cnt, exp_wc);
    end
    bus.out_ready = 1'b1;
    tick();
    exp_wc = exp_wc + 8'd1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.word_cnt !== exp_wc) begin
      errors++;
      $display("FAIL flush_handshake: got valid=%b cnt=%0d want 0 %0d", bus.out_valid, bus.word_cnt, exp_wc);
    end
    bus.flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] w1;
    logic [7:0] w2;
    w1 = 8'h4D;
    w2 = 8'h81;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit = w1[i];
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_bit = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h4D) begin
      errors++;
      $display("FAIL rstmid_pre: got valid=%b data=%h want 1 4d", bus.out_valid, bus.out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.word_cnt !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_async: got valid=%b data=%h cnt=%0d want 0 00 0", bus.out_valid, bus.out_data, bus.word_cnt);
    end
    #1;
    rst_n = 1'b1;
    exp_wc = 8'h00;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit = w2[i];
      tick();
      if (i < 7) begin
        vectors++;
        if (bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_stale: bit %0d got valid=%b want 0", i, bus.out_valid);
        end
      end
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h81) begin
      errors++;
      $display("FAIL rstmid_word: got valid=%b data=%h want 1 81", bus.out_valid, bus.out_data);
    end
    tick();
    exp_wc = exp_wc + 8'd1;
    vectors++;
    if (bus.word_cnt !== exp_wc) begin
      errors++;
      $display("FAIL rstmid_count: got %0d want %0d", bus.word_cnt, exp_wc);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] w;
    int         bad;
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    exp_wc = 8'h00;
    bus.out_ready = 1'b1;
    bad = 0;
    for (int n = 0; n < 256; n++) begin
      w = 8'(n * 37 + 11);
      for (int i = 0; i < 8; i++) begin
        bus.in_valid = 1'b1;
        bus.in_bit = w[i];
        tick();
      end
      if (bus.out_valid !== 1'b1 || bus.out_data !== w) bad++;
      if (n == 254) begin
        bus.in_valid = 1'b0;
        tick();
        vectors++;
        if (bus.word_cnt !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255: got %0d want 255", bus.word_cnt);
        end
      end
    end
    bus.in_valid = 1'b0;
    tick();
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wrap_words: %0d words wrong, want 0", bad);
    end
    vectors++;
    if (bus.word_cnt !== 8'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_zero: got cnt=%0d valid=%b in_ready=%b want 0 0 1", bus.word_cnt, bus.out_valid, bus.in_ready);
    end
  endtask

  initial begin
    vectors = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
